// File: rtl/i2c_wb_arbiter.sv
`default_nettype none
// ============================================================================
// i2c_wb_arbiter : round-robin, cyc-locked two-master WISHBONE arbiter with an
//                  ack watchdog, feeding the single i2c_x12_top slave port.
// Revision 1.0
// ============================================================================
module i2c_wb_arbiter #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       m0_cyc_i,
  input  logic       m0_stb_i,
  input  logic       m0_we_i,
  input  logic [6:0] m0_adr_i,
  input  logic [7:0] m0_dat_i,
  output logic [7:0] m0_dat_o,
  output logic       m0_ack_o,
  output logic       m0_err_o,
  input  logic       m1_cyc_i,
  input  logic       m1_stb_i,
  input  logic       m1_we_i,
  input  logic [6:0] m1_adr_i,
  input  logic [7:0] m1_dat_i,
  output logic [7:0] m1_dat_o,
  output logic       m1_ack_o,
  output logic       m1_err_o,
  output logic       s_cyc_o,
  output logic       s_stb_o,
  output logic       s_we_o,
  output logic [6:0] s_adr_o,
  output logic [7:0] s_dat_o,
  input  logic [7:0] s_dat_i,
  input  logic       s_ack_i,
  input  logic       s_err_i,
  output logic [1:0] grant_o,
  output logic       timeout_o
);

  localparam logic [7:0] WD_LIMIT = 8'(ACK_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT0  = 2'd1,
    GNT1  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic       last_owner_q, last_owner_d;
  logic [7:0] wd_q, wd_d;
  logic       owned, own_cyc, own_stb, fire;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      wd_q         <= 8'd0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      wd_q         <= wd_d;
    end
  end

  // The slave's ack/err in the limit cycle wins over the watchdog.
  always_comb begin
    owned   = (state_q == GNT0) || (state_q == GNT1);
    own_cyc = (state_q == GNT1) ? m1_cyc_i : m0_cyc_i;
    own_stb = (state_q == GNT1) ? m1_stb_i : m0_stb_i;
    fire    = owned && own_stb && !s_ack_i && !s_err_i && (wd_q == WD_LIMIT);
  end

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    wd_d         = 8'd0;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_d = last_owner_q ? GNT0 : GNT1;
        else if (m0_cyc_i)        state_d = GNT0;
        else if (m1_cyc_i)        state_d = GNT1;
      end
      GNT0, GNT1: begin
        if (!own_cyc || fire) begin
          state_d      = FLUSH;
          last_owner_d = (state_q == GNT1);
        end else if (own_stb && !s_ack_i && !s_err_i) begin
          wd_d = wd_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_adr_o   = 7'd0;
    s_dat_o   = 8'd0;
    m0_ack_o  = 1'b0;
    m0_err_o  = 1'b0;
    m0_dat_o  = 8'd0;
    m1_ack_o  = 1'b0;
    m1_err_o  = 1'b0;
    m1_dat_o  = 8'd0;
    grant_o   = {state_q == GNT1, state_q == GNT0};
    timeout_o = fire;
    if (state_q == GNT0) begin
      s_cyc_o  = m0_cyc_i && !fire;
      s_stb_o  = m0_stb_i && !fire;
      s_we_o   = m0_we_i;
      s_adr_o  = m0_adr_i;
      s_dat_o  = m0_dat_i;
      m0_ack_o = s_ack_i;
      m0_err_o = s_err_i || fire;
      m0_dat_o = s_dat_i;
    end else if (state_q == GNT1) begin
      s_cyc_o  = m1_cyc_i && !fire;
      s_stb_o  = m1_stb_i && !fire;
      s_we_o   = m1_we_i;
      s_adr_o  = m1_adr_i;
      s_dat_o  = m1_dat_i;
      m1_ack_o = s_ack_i;
      m1_err_o = s_err_i || fire;
      m1_dat_o = s_dat_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_wb_arbiter.sv
`default_nettype none
// ============================================================================
// tb_i2c_wb_arbiter : directed scenarios plus randomized two-master traffic
//                     checked against a transaction-level reference model.
// Revision 1.0
// ============================================================================
module tb_i2c_wb_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] m_cyc, m_stb, m_we;
  logic [6:0] m_adr  [2];
  logic [7:0] m_wdat [2];
  logic [7:0] m0_dat_o, m1_dat_o;
  logic       m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic       s_cyc_o, s_stb_o, s_we_o, timeout_o;
  logic [6:0] s_adr_o;
  logic [7:0] s_dat_o, s_dat_i;
  logic       s_ack_i, s_err_i;
  logic [1:0] grant_o;

  logic       auto_ack, man_ack;
  logic [7:0] auto_dat, man_dat;
  assign s_ack_i = auto_ack | man_ack;
  assign s_dat_i = auto_dat | man_dat;

  logic [40:0] all_outs;
  assign all_outs = {grant_o, timeout_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
                     m0_ack_o, m0_err_o, m0_dat_o, m1_ack_o, m1_err_o, m1_dat_o};

  always #5 clk = ~clk;

  i2c_wb_arbiter #(.ACK_TIMEOUT(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_we_i(m_we[0]),
    .m0_adr_i(m_adr[0]), .m0_dat_i(m_wdat[0]), .m0_dat_o(m0_dat_o),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_we_i(m_we[1]),
    .m1_adr_i(m_adr[1]), .m1_dat_i(m_wdat[1]), .m1_dat_o(m1_dat_o),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference memory: what the slave should hold after every completed write.
  logic [7:0] ref_mem   [128];
  logic [7:0] slave_mem [128];
  bit         slave_en    = 1'b1;
  int         slave_delay = -1;
  bit         wd_allowed  = 1'b0;

  initial begin : slave_model
    int d;
    auto_ack = 1'b0;
    auto_dat = 8'd0;
    for (int i = 0; i < 128; i++) slave_mem[i] = 8'd0;
    forever begin
      @(negedge clk);
      if (slave_en && s_cyc_o && s_stb_o) begin
        d = (slave_delay < 0) ? int'($urandom_range(0, 3)) : slave_delay;
        repeat (d) @(negedge clk);
        tick();
        if (s_we_o) slave_mem[s_adr_o] = s_dat_o;
        else        auto_dat = slave_mem[s_adr_o];
        auto_ack = 1'b1;
        tick();
        auto_ack = 1'b0;
        auto_dat = 8'd0;
      end
    end
  end

  // Event-level monitor: ownership changes, round-robin choice and routing.
  logic [1:0] grant_log [$];
  int         gap_log   [$];
  int         ack_cnt [2];
  int         err_cnt [2];
  int         to_cnt;

  initial begin : monitor
    logic [1:0] prev_grant, prev_cyc, exp_g;
    logic       prev_to, last_model;
    logic [1:0] ack_v, err_v;
    logic [7:0] mdat [2];
    int         gap, o;
    prev_grant = 2'b00; prev_cyc = 2'b00; prev_to = 1'b0; last_model = 1'b1; gap = 100;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_grant = 2'b00; prev_cyc = 2'b00; prev_to = 1'b0; last_model = 1'b1; gap = 100;
      end else begin
        ack_v = {m1_ack_o, m0_ack_o};
        err_v = {m1_err_o, m0_err_o};
        mdat[0] = m0_dat_o;
        mdat[1] = m1_dat_o;
        ack_cnt[0] += int'(m0_ack_o);
        ack_cnt[1] += int'(m1_ack_o);
        err_cnt[0] += int'(m0_err_o);
        err_cnt[1] += int'(m1_err_o);
        to_cnt     += int'(timeout_o);
        check("spurious_timeout", timeout_o & ~wd_allowed, 0);
        if (prev_grant == 2'b00 && grant_o != 2'b00) begin
          exp_g = (prev_cyc == 2'b11) ? (last_model ? 2'b01 : 2'b10)
                                      : (prev_cyc[0] ? 2'b01 : 2'b10);
          check("rr_owner", grant_o, exp_g);
          check("flush_gap", gap >= 2, 1);
          grant_log.push_back(grant_o);
          gap_log.push_back(gap);
        end
        if (prev_grant != 2'b00) begin
          check("hold", grant_o, ((prev_cyc & prev_grant) != 2'b00 && !prev_to) ? prev_grant : 2'b00);
          if (grant_o == 2'b00) last_model = prev_grant[1];
        end
        if (grant_o == 2'b01 || grant_o == 2'b10) begin
          o = grant_o[1] ? 1 : 0;
          check("s_ctl", {s_cyc_o, s_stb_o}, {m_cyc[o] & ~timeout_o, m_stb[o] & ~timeout_o});
          if (s_stb_o) check("s_req", {s_we_o, s_adr_o, s_dat_o}, {m_we[o], m_adr[o], m_wdat[o]});
          check("own_resp", {ack_v[o], err_v[o], mdat[o]}, {s_ack_i, s_err_i | timeout_o, s_dat_i});
          check("other_resp", {ack_v[1-o], err_v[1-o], mdat[1-o]}, 0);
        end else begin
          check("idle_bus", {grant_o, s_cyc_o, s_stb_o, ack_v, err_v, timeout_o}, 0);
        end
        gap = (grant_o == 2'b00) ? gap + 1 : 0;
        prev_grant = grant_o;
        prev_cyc   = m_cyc;
        prev_to    = timeout_o;
      end
    end
  end

  task automatic wait_resp(input int m, output int n, output logic got_ack,
                           output logic got_err, output logic [7:0] rd);
    got_ack = 1'b0; got_err = 1'b0; rd = 8'd0; n = 0;
    while (!got_ack && !got_err && n < 300) begin
      @(negedge clk);
      n++;
      got_ack = (m == 1) ? m1_ack_o : m0_ack_o;
      got_err = (m == 1) ? m1_err_o : m0_err_o;
      rd      = (m == 1) ? m1_dat_o : m0_dat_o;
    end
    check("resp_bound", got_ack | got_err, 1);
  endtask

  task automatic bus_access(input int m, input logic we, input logic [6:0] adr, input logic [7:0] dat);
    int n; logic a, e; logic [7:0] rd;
    m_stb[m] = 1'b1; m_we[m] = we; m_adr[m] = adr; m_wdat[m] = dat;
    wait_resp(m, n, a, e, rd);
    if (a) begin
      if (we) ref_mem[adr] = dat;
      else    check("read_data", rd, ref_mem[adr]);
    end
    tick();
    m_stb[m] = 1'b0; m_we[m] = 1'b0;
  endtask

  task automatic run_master(input int m);
    int k;
    repeat (25) begin
      repeat ($urandom_range(0, 4)) tick();
      tick();
      m_cyc[m] = 1'b1;
      k = $urandom_range(1, 3);
      for (int i = 0; i < k; i++)
        bus_access(m, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 15)), 8'($urandom));
      m_cyc[m] = 1'b0;
    end
  endtask

  task automatic apply_reset();
    tick(); rst = 1'b1;
    tick(); tick(); rst = 1'b0;
  endtask

  task automatic clear_counts();
    ack_cnt[0] = 0; ack_cnt[1] = 0; err_cnt[0] = 0; err_cnt[1] = 0; to_cnt = 0;
  endtask

  initial begin : watchdog_global
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int n, base, early;
    logic a, e;
    logic [7:0] rd;
    m_cyc = 2'b00; m_stb = 2'b00; m_we = 2'b00;
    m_adr[0] = 7'd0; m_adr[1] = 7'd0; m_wdat[0] = 8'd0; m_wdat[1] = 8'd0;
    man_ack = 1'b0; man_dat = 8'd0; s_err_i = 1'b0;
    for (int i = 0; i < 128; i++) ref_mem[i] = 8'd0;
    clear_counts();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_state", all_outs, 0);

    // Grant and single write, slave acks two cycles after stb.
    slave_delay = 1;
    clear_counts();
    tick();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1; m_adr[0] = 7'h03; m_wdat[0] = 8'hA5;
    @(negedge clk); check("t1_grant_latency", grant_o, 2'b00);
    @(negedge clk); check("t1_grant", grant_o, 2'b01);
    check("t1_slave_req", {s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o}, {3'b111, 7'h03, 8'hA5});
    wait_resp(0, n, a, e, rd);
    check("t1_ack_latency", n, 2);
    tick();
    m_stb[0] = 1'b0; m_we[0] = 1'b0; m_cyc[0] = 1'b0;
    ref_mem[3] = 8'hA5;
    repeat (3) @(negedge clk);
    check("t1_m0_acks", ack_cnt[0], 1);
    check("t1_m1_acks", ack_cnt[1], 0);
    check("t1_slave_mem", slave_mem[3], 8'hA5);
    slave_delay = -1;

    // Tie-break after reset: m0 first, then m1 after FLUSH + IDLE.
    apply_reset();
    base = grant_log.size();
    fork
      begin tick(); m_cyc[0] = 1'b1; bus_access(0, 1'b0, 7'h03, 8'h00); m_cyc[0] = 1'b0; end
      begin tick(); m_cyc[1] = 1'b1; bus_access(1, 1'b0, 7'h03, 8'h00); m_cyc[1] = 1'b0; end
    join
    repeat (3) @(negedge clk);
    check("t2_grant_count", grant_log.size() - base, 2);
    check("t2_first", grant_log[base], 2'b01);
    check("t2_second", grant_log[base+1], 2'b10);
    check("t2_gap", gap_log[base+1], 2);

    // Lock: m1 holds cyc over three accesses while m0 waits.
    base = grant_log.size();
    fork
      begin
        tick(); m_cyc[1] = 1'b1;
        bus_access(1, 1'b0, 7'h04, 8'h00);
        bus_access(1, 1'b0, 7'h04, 8'h00);
        bus_access(1, 1'b1, 7'h04, 8'h90);
        m_cyc[1] = 1'b0;
      end
      begin tick(); tick(); m_cyc[0] = 1'b1; bus_access(0, 1'b0, 7'h04, 8'h00); m_cyc[0] = 1'b0; end
    join
    repeat (3) @(negedge clk);
    check("t3_grant_count", grant_log.size() - base, 2);
    check("t3_first", grant_log[base], 2'b10);
    check("t3_second", grant_log[base+1], 2'b01);
    check("t3_gap", gap_log[base+1], 2);

    // Watchdog: no ack, err/timeout exactly 8 cycles after stb reaches the slave.
    slave_en = 1'b0; wd_allowed = 1'b1;
    clear_counts();
    tick();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0; m_adr[0] = 7'h05;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_stb_o && n < 20);
    check("t4_granted", s_stb_o, 1);
    early = 0;
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      early += int'(m0_err_o | timeout_o);
    end
    check("t4_no_early_err", early, 0);
    @(negedge clk);
    check("t4_timeout", {m0_err_o, timeout_o, s_cyc_o, s_stb_o, m0_ack_o}, 5'b11000);
    tick();
    man_ack = 1'b1; m_stb[0] = 1'b0; m_cyc[0] = 1'b0;
    @(negedge clk);
    check("t4_late_ack", {m0_ack_o, m0_err_o, timeout_o}, 3'b000);
    tick(); man_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("t4_timeout_pulses", to_cnt, 1);
    check("t4_err_pulses", err_cnt[0], 1);
    wd_allowed = 1'b0;

    // Ack arrives in the very cycle the watchdog would fire.
    clear_counts();
    tick();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0; m_adr[0] = 7'h06;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_stb_o && n < 20);
    check("t5_granted", s_stb_o, 1);
    repeat (7) @(negedge clk);
    tick();
    man_ack = 1'b1; man_dat = 8'h3C;
    @(negedge clk);
    check("t5_race", {m0_ack_o, m0_err_o, timeout_o, m0_dat_o}, {3'b100, 8'h3C});
    tick();
    man_ack = 1'b0; man_dat = 8'd0; m_stb[0] = 1'b0; m_cyc[0] = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_no_timeout", to_cnt, 0);

    // Reset in the middle of an m1 access, then a tie goes to m0.
    tick();
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b1; m_adr[1] = 7'h7F; m_wdat[1] = 8'hFF;
    n = 0;
    do begin @(negedge clk); n++; end while (!(grant_o == 2'b10 && s_stb_o) && n < 20);
    check("t6_in_gnt1", grant_o, 2'b10);
    tick(); rst = 1'b1;
    tick();
    rst = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0; m_we[1] = 1'b0;
    man_ack = 1'b1; man_dat = 8'h5A;
    @(negedge clk);
    check("t6_after_reset", all_outs, 0);
    tick(); man_ack = 1'b0; man_dat = 8'd0;
    slave_en = 1'b1;
    base = grant_log.size();
    fork
      begin tick(); m_cyc[0] = 1'b1; bus_access(0, 1'b0, 7'h7F, 8'h00); m_cyc[0] = 1'b0; end
      begin tick(); m_cyc[1] = 1'b1; bus_access(1, 1'b0, 7'h7F, 8'h00); m_cyc[1] = 1'b0; end
    join
    repeat (3) @(negedge clk);
    check("t6_tie_after_reset", grant_log[base], 2'b01);

    // Randomized traffic from both masters.
    fork
      run_master(0);
      run_master(1);
    join
    repeat (4) @(negedge clk);
    check("rand_idle_end", grant_o, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
